sgb_packet_rx: RTL and testbench
================================

Name: sgb_packet_rx

Overview:
Receives Super Game Boy command packets that the Game Boy CPU bit-bangs onto the joypad select lines (joy_p54 from the GB core). Decodes reset pulses, 128 data bits and the stop bit. Delivers complete 16-byte packets, tagged with command and multi-packet position, to the SNES-side SGB register/command logic. Sits directly downstream of the GB core's joy_p54 output, in parallel with the joypad multiplexer.

Parameters:
TIMEOUT_CYC, 16'd65535, number of clk_en ticks without a pulse before a partial packet is aborted (only used when SGB_PKT_TIMEOUT_EN is defined).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
clk_en  in  1  GB clock enable; all sampling and state updates occur only on clk_en=1
enable  in  1  receiver enable; 0 forces IDLE and drops any partial packet
joy_p54  in  2  [0]=P14, [1]=P15 as driven by the GB; 0 = line pulled low
pkt_valid  out  1  one-clk pulse; pkt_* outputs are valid
pkt_data  out  128  packet bytes; byte n occupies bits [8n+7:8n]; each byte received LSB first
pkt_cmd  out  5  command of the current multi-packet sequence (byte0[7:3] of its first packet)
pkt_idx  out  3  packet index within the sequence, 0-based
pkt_last  out  1  this packet completes the sequence
pkt_err  out  1  one-clk pulse; packet discarded because the stop bit was 1 or a timeout occurred

Behaviour:
- Reset: all outputs 0. State IDLE. Bit counter 0. Sequence length 0.
- Pulse decode uses joy_p54 sampled on clk_en. The level after a 2'b11 sample classifies the pulse:
  - 2'b00 = RESET pulse
  - 2'b10 = bit 0
  - 2'b01 = bit 1
  - A pulse is consumed only on the first non-11 sample after at least one 11 sample; holding a level is not a repeat.
- States:
  - IDLE: on RESET pulse go to BITS with counter 0. Data pulses are ignored.
  - BITS: each data pulse shifts into pkt_data position counter[6:0], counter increments. After bit 127, go to STOP.
  - STOP: on a bit-0 pulse, emit pkt_valid for one clk, then go to IDLE. On a bit-1 pulse, emit pkt_err and go to IDLE.
  - RESET pulse in BITS or STOP: discard the partial packet and restart BITS at counter 0. No pkt_err is raised.
- Sequence tracking:
  - If the remaining count is 0 at packet completion, the packet is a first packet: latch pkt_cmd=byte0[7:3], len=byte0[2:0] (len 0 treated as 1), pkt_idx=0.
  - Otherwise pkt_idx = previous pkt_idx+1 and pkt_cmd is held.
  - pkt_last=1 when pkt_idx+1 == len. Remaining count then returns to 0.
- Latency: pkt_valid is asserted on the clk following the clk_en sample that detected the stop bit. pkt_data is stable until the next pkt_valid.
- enable=0 or reset_n low mid-packet: drop the packet and clear sequence tracking; no pulses are emitted.
- pkt_err also clears sequence tracking.

Optional Feature:
SGB_PKT_TIMEOUT_EN:
- Defined: a 16-bit counter of clk_en ticks runs in BITS/STOP and is cleared on every consumed pulse. Reaching TIMEOUT_CYC emits pkt_err and returns to IDLE.
- Undefined: no counter exists; a partial packet waits indefinitely.

Decomposition:
- Package sgb_pkg:
  - state enum {IDLE, BITS, STOP}
  - pulse enum {P_NONE, P_RESET, P_ZERO, P_ONE}
  - constants PKT_BITS=128, CMD_LEN_MAX=7
- One sub-module, sgb_pulse_decode: edge/level classifier emitting the pulse code on clk_en.
- The top level holds the FSM, shift register and sequence tracker.

Test Plan:
- Single packet: RESET, bytes 0x89 (cmd 0x11 MLT_REQ, len 1), 0x01, 14×0x00, stop 0 -> one pkt_valid; pkt_data[15:0]=16'h0189, pkt_cmd=5'h11, pkt_idx=0, pkt_last=1.
- Multi-packet: first packet byte0=0x3B (cmd 7, len 3), followed by two further packets -> pkt_idx 0,1,2; pkt_last only on idx 2; pkt_cmd=7 on all three.
- Bad stop: valid 128 bits, stop bit 1 -> pkt_err pulse, no pkt_valid. The next good packet is then treated as a first packet.
- Mid-packet restart: 40 bits, RESET, full packet -> exactly one pkt_valid carrying only the second packet's data; no pkt_err.
- Held levels and idle noise: bit-1 level held for 10 clk_en ticks counts once; data pulses in IDLE produce no output. Asserting reset_n low at bit 64 clears all outputs to 0.
- With SGB_PKT_TIMEOUT_EN and TIMEOUT_CYC=100: stall after bit 20 -> pkt_err exactly 100 clk_en ticks after the last pulse, state IDLE.

Source files
------------

// File: rtl/sgb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sgb_pkg
//  Purpose  : Shared types and constants for the Super Game Boy packet
//             receiver (receiver states, joypad pulse codes, level decoder).
//  Revision : 1.0  initial release
// ============================================================================
package sgb_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BITS = 2'd1,
        STOP = 2'd2
    } state_t;

    // Pulse codes produced by the joypad line decoder
    typedef enum logic [1:0] {
        P_NONE  = 2'd0,
        P_RESET = 2'd1,
        P_ZERO  = 2'd2,
        P_ONE   = 2'd3
    } pulse_t;

    localparam int PKT_BITS    = 128;
    localparam int CMD_LEN_MAX = 7;

    // Map a non-idle P15/P14 level to the pulse it represents.
    // Both lines low is a reset, P14 low alone is a 0, P15 low alone is a 1.
    function automatic pulse_t classify_level(input logic [1:0] lvl);
        pulse_t code;
        case (lvl)
            2'b00:   code = P_RESET;
            2'b10:   code = P_ZERO;
            2'b01:   code = P_ONE;
            default: code = P_NONE;
        endcase
        return code;
    endfunction

endpackage : sgb_pkg
`default_nettype wire

// File: rtl/sgb_pulse_decode.sv
`default_nettype none
// ============================================================================
//  Module   : sgb_pulse_decode
//  Purpose  : Classifies bit-banged SGB pulses on the joypad select lines.
//             A pulse is reported once, on the first non-idle (non-11)
//             sample that directly follows an idle 11 sample; holding a
//             level produces no further pulses.
//  Revision : 1.0  initial release
// ============================================================================
module sgb_pulse_decode
    import sgb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       clk_en,
    input  logic [1:0] joy_p54,
    output pulse_t     pulse
);

    // High when the previous clk_en sample saw both lines released (11)
    logic armed;

    // Remember whether the last sample was idle so the next low level fires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed <= 1'b0;
        end else if (clk_en) begin
            armed <= (joy_p54 == 2'b11);
        end
    end

    // Pulse is combinational so the FSM can act on the same clk_en sample
    assign pulse = (clk_en && armed) ? classify_level(joy_p54) : P_NONE;

endmodule : sgb_pulse_decode
`default_nettype wire

// File: rtl/sgb_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sgb_packet_rx
//  Purpose  : Super Game Boy command packet receiver. Decodes reset pulses,
//             128 data bits and a stop bit from joy_p54, delivers complete
//             16-byte packets tagged with command and multi-packet position.
//  Options  : SGB_PKT_TIMEOUT_EN - when defined, a partial packet is aborted
//             with pkt_err after TIMEOUT_CYC clk_en ticks without a pulse.
//  Revision : 1.0  initial release
// ============================================================================
module sgb_packet_rx
    import sgb_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYC = 16'd65535
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clk_en,
    input  logic                enable,
    input  logic [1:0]          joy_p54,
    output logic                pkt_valid,
    output logic [PKT_BITS-1:0] pkt_data,
    output logic [4:0]          pkt_cmd,
    output logic [2:0]          pkt_idx,
    output logic                pkt_last,
    output logic                pkt_err
);

    pulse_t              pulse;
    state_t              state;
    logic [6:0]          bit_cnt;
    logic [PKT_BITS-1:0] shift_reg;
    logic [2:0]          seq_len;
    logic [2:0]          seq_rem;
    logic [2:0]          len_raw;
    logic [2:0]          first_len;
    logic [2:0]          next_idx;
    logic                timeout_hit;

    sgb_pulse_decode u_pulse_decode (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .joy_p54 (joy_p54),
        .pulse   (pulse)
    );

    // Length field of a first packet; a zero length still means one packet
    assign len_raw   = shift_reg[2:0];
    assign first_len = (len_raw == 3'd0)              ? 3'd1 :
                       (len_raw > 3'(CMD_LEN_MAX))    ? 3'(CMD_LEN_MAX) :
                                                        len_raw;
    assign next_idx  = pkt_idx + 3'd1;

`ifdef SGB_PKT_TIMEOUT_EN
    logic [15:0] idle_ticks;

    // Count clk_en ticks since the last consumed pulse while a packet is open
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_ticks <= 16'd0;
        end else if (!enable || state == IDLE || pulse != P_NONE) begin
            idle_ticks <= 16'd0;
        end else if (clk_en) begin
            idle_ticks <= idle_ticks + 16'd1;
        end
    end

    // Fires on the TIMEOUT_CYC-th pulse-free tick after the last pulse
    assign timeout_hit = clk_en && enable && (state != IDLE) &&
                         (pulse == P_NONE) &&
                         (idle_ticks == TIMEOUT_CYC - 16'd1);
`else
    logic unused_timeout_cfg;

    // Without the watchdog a partial packet waits indefinitely
    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

    // Receiver FSM, shift register and multi-packet sequence tracker
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            bit_cnt   <= 7'd0;
            shift_reg <= '0;
            seq_len   <= 3'd0;
            seq_rem   <= 3'd0;
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;
            pkt_data  <= '0;
            pkt_cmd   <= 5'd0;
            pkt_idx   <= 3'd0;
            pkt_last  <= 1'b0;
        end else begin
            pkt_valid <= 1'b0;
            pkt_err   <= 1'b0;

            if (!enable) begin
                // Receiver disabled: drop partial packet and any open sequence
                state   <= IDLE;
                bit_cnt <= 7'd0;
                seq_len <= 3'd0;
                seq_rem <= 3'd0;
            end else if (timeout_hit) begin
                state   <= IDLE;
                bit_cnt <= 7'd0;
                seq_len <= 3'd0;
                seq_rem <= 3'd0;
                pkt_err <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        // Data pulses are noise until a reset pulse opens a packet
                        if (pulse == P_RESET) begin
                            state   <= BITS;
                            bit_cnt <= 7'd0;
                        end
                    end

                    BITS: begin
                        if (pulse == P_RESET) begin
                            bit_cnt <= 7'd0;
                        end else if (pulse == P_ZERO || pulse == P_ONE) begin
                            shift_reg[bit_cnt] <= (pulse == P_ONE);
                            bit_cnt            <= bit_cnt + 7'd1;
                            if (bit_cnt == 7'(PKT_BITS - 1)) begin
                                state <= STOP;
                            end
                        end
                    end

                    STOP: begin
                        case (pulse)
                            P_RESET: begin
                                state   <= BITS;
                                bit_cnt <= 7'd0;
                            end
                            P_ZERO: begin
                                state     <= IDLE;
                                pkt_valid <= 1'b1;
                                pkt_data  <= shift_reg;
                                if (seq_rem == 3'd0) begin
                                    // First packet of a sequence carries cmd/len
                                    pkt_cmd  <= shift_reg[7:3];
                                    pkt_idx  <= 3'd0;
                                    seq_len  <= first_len;
                                    pkt_last <= (first_len == 3'd1);
                                    seq_rem  <= first_len - 3'd1;
                                end else begin
                                    pkt_idx  <= next_idx;
                                    pkt_last <= ((next_idx + 3'd1) == seq_len);
                                    seq_rem  <= seq_rem - 3'd1;
                                end
                            end
                            P_ONE: begin
                                // Bad stop bit: discard and forget the sequence
                                state   <= IDLE;
                                pkt_err <= 1'b1;
                                seq_len <= 3'd0;
                                seq_rem <= 3'd0;
                            end
                            default: ;
                        endcase
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule : sgb_packet_rx
`default_nettype wire

// File: tb/tb_sgb_packet_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sgb_packet_rx
//  Purpose  : Directed self-checking bench for sgb_packet_rx.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sgb_packet_rx;
    import sgb_pkg::*;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         clk_en  = 1'b0;
    logic         enable  = 1'b0;
    logic [1:0]   joy_p54 = 2'b11;
    logic         pkt_valid;
    logic [127:0] pkt_data;
    logic [4:0]   pkt_cmd;
    logic [2:0]   pkt_idx;
    logic         pkt_last;
    logic         pkt_err;

    int tests     = 0;
    int fails     = 0;
    int valid_cnt = 0;
    int err_cnt   = 0;
    int vb;
    int eb;
    int hit;

    localparam logic [127:0] P1 = 128'h0189;
    localparam logic [127:0] PA = 128'h11223344_55667788_99AABBCC_DDEEFF3B;
    localparam logic [127:0] PB = 128'h01234567_89ABCDEF_0F1E2D3C_4B5A6978;
    localparam logic [127:0] PC = 128'hFEDCBA98_76543210_F0E1D2C3_B4A59687;
    localparam logic [127:0] S2 = 128'hC0DE002A;
    localparam logic [127:0] PR = 128'h5A89;
    localparam logic [127:0] ONES = {128{1'b1}};

    sgb_packet_rx #(.TIMEOUT_CYC(16'd100)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .enable    (enable),
        .joy_p54   (joy_p54),
        .pkt_valid (pkt_valid),
        .pkt_data  (pkt_data),
        .pkt_cmd   (pkt_cmd),
        .pkt_idx   (pkt_idx),
        .pkt_last  (pkt_last),
        .pkt_err   (pkt_err)
    );

    always #5 clk = ~clk;

    // clk_en is high on every other rising edge
    always @(negedge clk) clk_en = ~clk_en;

    // Count single-clk output pulses
    always @(negedge clk) begin
        if (pkt_valid) valid_cnt++;
        if (pkt_err)   err_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        while (!clk_en) @(posedge clk);
        #1;
    endtask

    task automatic pulse_lvl(input logic [1:0] lvl);
        joy_p54 = 2'b11;
        tick();
        joy_p54 = lvl;
        tick();
    endtask

    task automatic send_bit(input logic b);
        pulse_lvl(b ? 2'b01 : 2'b10);
    endtask

    task automatic send_reset();
        pulse_lvl(2'b00);
    endtask

    task automatic idle(input int n);
        joy_p54 = 2'b11;
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [127:0] d, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_bit(d[i]);
    endtask

    task automatic send_packet(input logic [127:0] d, input logic stop);
        send_reset();
        send_bits(d, 0, 127);
        send_bit(stop);
        idle(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (4) @(posedge clk);
        #2;
        chk("rst_valid", pkt_valid, 0);
        chk("rst_err",   pkt_err,   0);
        chk("rst_data",  pkt_data,  0);
        chk("rst_cmd",   pkt_cmd,   0);
        chk("rst_idx",   pkt_idx,   0);
        chk("rst_last",  pkt_last,  0);
        chk("rst_state", dut.state, IDLE);
        reset_n = 1'b1;
        enable  = 1'b1;
        idle(4);

        // Single MLT_REQ packet
        vb = valid_cnt; eb = err_cnt;
        send_packet(P1, 1'b0);
        chk("single_cnt",  valid_cnt - vb, 1);
        chk("single_err",  err_cnt - eb, 0);
        chk("single_lo16", pkt_data[15:0], 16'h0189);
        chk("single_data", pkt_data, P1);
        chk("single_cmd",  pkt_cmd, 5'h11);
        chk("single_idx",  pkt_idx, 0);
        chk("single_last", pkt_last, 1);

        // Three-packet sequence, cmd 7
        vb = valid_cnt;
        send_packet(PA, 1'b0);
        chk("multi0_data", pkt_data, PA);
        chk("multi0_cmd",  pkt_cmd, 5'd7);
        chk("multi0_idx",  pkt_idx, 0);
        chk("multi0_last", pkt_last, 0);
        send_packet(PB, 1'b0);
        chk("multi1_data", pkt_data, PB);
        chk("multi1_cmd",  pkt_cmd, 5'd7);
        chk("multi1_idx",  pkt_idx, 1);
        chk("multi1_last", pkt_last, 0);
        send_packet(PC, 1'b0);
        chk("multi2_data", pkt_data, PC);
        chk("multi2_cmd",  pkt_cmd, 5'd7);
        chk("multi2_idx",  pkt_idx, 2);
        chk("multi2_last", pkt_last, 1);
        chk("multi_cnt",   valid_cnt - vb, 3);

        // Bad stop bit in the middle of a two-packet sequence
        send_packet(S2, 1'b0);
        chk("s2_cmd",  pkt_cmd, 5'd5);
        chk("s2_idx",  pkt_idx, 0);
        chk("s2_last", pkt_last, 0);
        vb = valid_cnt; eb = err_cnt;
        send_packet(S2 ^ 128'hFF00, 1'b1);
        chk("badstop_err",   err_cnt - eb, 1);
        chk("badstop_valid", valid_cnt - vb, 0);
        chk("badstop_hold",  pkt_data, S2);
        send_packet(P1, 1'b0);
        chk("after_err_cmd",  pkt_cmd, 5'h11);
        chk("after_err_idx",  pkt_idx, 0);
        chk("after_err_last", pkt_last, 1);

        // Restart after 40 bits
        vb = valid_cnt; eb = err_cnt;
        send_reset();
        send_bits(ONES, 0, 39);
        send_packet(PR, 1'b0);
        chk("restart_cnt",  valid_cnt - vb, 1);
        chk("restart_err",  err_cnt - eb, 0);
        chk("restart_data", pkt_data, PR);

        // Data pulses while idle
        vb = valid_cnt; eb = err_cnt;
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        idle(3);
        chk("noise_valid", valid_cnt - vb, 0);
        chk("noise_err",   err_cnt - eb, 0);
        chk("noise_state", dut.state, IDLE);

        // First bit held low-level for 10 ticks counts once
        vb = valid_cnt;
        send_reset();
        joy_p54 = 2'b11;
        tick();
        joy_p54 = 2'b01;
        repeat (10) tick();
        send_bits(P1, 1, 127);
        send_bit(1'b0);
        idle(3);
        chk("held_cnt",  valid_cnt - vb, 1);
        chk("held_data", pkt_data, P1);

        // Enable drop mid-packet clears sequence and drops packet
        send_packet(S2, 1'b0);
        vb = valid_cnt; eb = err_cnt;
        send_reset();
        send_bits(PB, 0, 49);
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        send_bits(PB, 50, 127);
        send_bit(1'b0);
        idle(3);
        chk("dis_valid", valid_cnt - vb, 0);
        chk("dis_err",   err_cnt - eb, 0);
        send_packet(P1, 1'b0);
        chk("dis_next_cmd",  pkt_cmd, 5'h11);
        chk("dis_next_idx",  pkt_idx, 0);
        chk("dis_next_last", pkt_last, 1);

        // Asynchronous reset at bit 64
        send_packet(S2, 1'b0);
        send_reset();
        send_bits(PA, 0, 63);
        reset_n = 1'b0;
        #1;
        chk("arst_data",  pkt_data, 0);
        chk("arst_cmd",   pkt_cmd, 0);
        chk("arst_idx",   pkt_idx, 0);
        chk("arst_last",  pkt_last, 0);
        chk("arst_valid", pkt_valid, 0);
        chk("arst_err",   pkt_err, 0);
        #3;
        reset_n = 1'b1;
        idle(2);
        vb = valid_cnt;
        send_packet(PR, 1'b0);
        chk("arst_next_cnt",  valid_cnt - vb, 1);
        chk("arst_next_data", pkt_data, PR);
        chk("arst_next_cmd",  pkt_cmd, 5'h11);
        chk("arst_next_last", pkt_last, 1);

`ifdef SGB_PKT_TIMEOUT_EN
        // Stall after 20 bits: error exactly 100 ticks after the last pulse
        vb = valid_cnt; eb = err_cnt;
        send_reset();
        send_bits(PA, 0, 19);
        joy_p54 = 2'b11;
        hit = 0;
        for (int k = 1; k <= 200 && hit == 0; k++) begin
            tick();
            if (pkt_err) hit = k;
        end
        idle(2);
        chk("to_delay", hit, 100);
        chk("to_state", dut.state, IDLE);
        chk("to_err",   err_cnt - eb, 1);
        chk("to_valid", valid_cnt - vb, 0);
`else
        // Without the watchdog a stalled packet resumes and completes
        vb = valid_cnt; eb = err_cnt;
        send_reset();
        send_bits(PA, 0, 19);
        idle(300);
        chk("stall_err", err_cnt - eb, 0);
        send_bits(PA, 20, 127);
        send_bit(1'b0);
        idle(3);
        chk("stall_cnt",  valid_cnt - vb, 1);
        chk("stall_data", pkt_data, PA);
        chk("stall_cmd",  pkt_cmd, 5'd7);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sgb_packet_rx
`default_nettype wire
